// File: rtl/sir_master_if.sv
// Host command/response port and Sir register bus, grouped so the initiator
// and its host/slave side can be wired with one connection.
interface sir_master_if #(
    parameter int ADDRWIDTH = 8,
    parameter int DATAWIDTH = 32
);
    logic                 CmdValid;
    logic                 CmdReady;
    logic                 CmdRead;
    logic [ADDRWIDTH-1:0] CmdAddr;
    logic [DATAWIDTH-1:0] CmdWdat;

    logic                 RspValid;
    logic [DATAWIDTH-1:0] RspRdat;
    logic                 RspTimeout;

    logic                 SirSel;
    logic                 SirRead;
    logic [ADDRWIDTH-1:0] SirAddr;
    logic [DATAWIDTH-1:0] SirWdat;
    logic                 SirDack;
    logic [DATAWIDTH-1:0] SirRdat;

    modport master (
        input  CmdValid, CmdRead, CmdAddr, CmdWdat, SirDack, SirRdat,
        output CmdReady, RspValid, RspRdat, RspTimeout,
        output SirSel, SirRead, SirAddr, SirWdat
    );

    modport slave (
        output CmdValid, CmdRead, CmdAddr, CmdWdat, SirDack, SirRdat,
        input  CmdReady, RspValid, RspRdat, RspTimeout,
        input  SirSel, SirRead, SirAddr, SirWdat
    );
endinterface

// File: rtl/sir_master.sv
// Sir bus initiator: one host read/write at a time, SirDack wait with timeout,
// single-cycle response pulse and an enforced SirSel-low gap between accesses.
//   state   | meaning
//   IDLE    | CmdReady high, waiting for a command
//   SEL     | SirSel high, counting cycles until SirDack or timeout
//   RESP    | RspValid pulse, SirSel low
//   GAP     | extra SirSel-low cycles so slave edge detectors re-arm
module sir_master #(
    parameter int ADDRWIDTH = 8,
    parameter int DATAWIDTH = 32,
    parameter int TOUTCYC   = 16,
    parameter int GAPCYC    = 1
) (
    input logic            clk,
    input logic            rst,
    sir_master_if.master   bus
);
    localparam int CW = $clog2(TOUTCYC + 1);
    localparam int GW = $clog2(GAPCYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEL,
        ST_RESP,
        ST_GAP
    } state_e;

    state_e               state_q;
    logic                 cmd_ready_q;
    logic                 sel_q;
    logic                 read_q;
    logic [ADDRWIDTH-1:0] addr_q;
    logic [DATAWIDTH-1:0] wdat_q;
    logic                 rsp_valid_q;
    logic [DATAWIDTH-1:0] rsp_rdat_q;
    logic                 rsp_tout_q;
    logic [CW-1:0]        sel_cnt_q;
    logic [CW-1:0]        sel_cnt_d;
    logic [GW-1:0]        gap_cnt_q;

    always_comb begin
        sel_cnt_d = sel_cnt_q;
        if (sel_cnt_q != CW'(TOUTCYC)) begin
            sel_cnt_d = sel_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            sel_q       <= 1'b0;
            read_q      <= 1'b0;
            addr_q      <= '0;
            wdat_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdat_q  <= '0;
            rsp_tout_q  <= 1'b0;
            sel_cnt_q   <= '0;
            gap_cnt_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.CmdValid && cmd_ready_q) begin
                        state_q     <= ST_SEL;
                        cmd_ready_q <= 1'b0;
                        sel_q       <= 1'b1;
                        read_q      <= bus.CmdRead;
                        addr_q      <= bus.CmdAddr;
                        wdat_q      <= bus.CmdWdat;
                        sel_cnt_q   <= CW'(1);
                    end
                end
                ST_SEL: begin
                    sel_cnt_q <= sel_cnt_d;
                    // First SEL cycle may still see the previous slave's acknowledge.
                    if (sel_cnt_q >= CW'(2) && bus.SirDack) begin
                        state_q     <= ST_RESP;
                        sel_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdat_q  <= read_q ? bus.SirRdat : '0;
                        rsp_tout_q  <= 1'b0;
                    end else if (sel_cnt_q >= CW'(TOUTCYC)) begin
                        state_q     <= ST_RESP;
                        sel_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdat_q  <= '0;
                        rsp_tout_q  <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (GAPCYC > 1) begin
                        state_q   <= ST_GAP;
                        gap_cnt_q <= GW'(GAPCYC - 1);
                    end else begin
                        state_q     <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GW'(1)) begin
                        state_q     <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GW'(1);
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    sel_q       <= 1'b0;
                end
            endcase
        end
    end

    // Ready register resets high so the host sees CmdReady the moment rst drops.
    assign bus.CmdReady   = cmd_ready_q & ~rst;
    assign bus.RspValid   = rsp_valid_q;
    assign bus.RspRdat    = rsp_rdat_q;
    assign bus.RspTimeout = rsp_tout_q;
    assign bus.SirSel     = sel_q;
    assign bus.SirRead    = read_q;
    assign bus.SirAddr    = addr_q;
    assign bus.SirWdat    = wdat_q;
endmodule

// File: doc/sir_master.md
# sir_master

Initiator for the Sir register bus. It accepts one register read or write command at a time from a host-side command port, such as a UART or SPI command decoder. It drives SirSel, SirRead, SirAddr and SirWdat to the register slaves, and waits for SirDack. It returns read data, or a timeout flag, on a single-cycle response port. The slaves' SirDack and SirRdat outputs are zero when unselected, so they are OR-combined before reaching this block.

## Interface
- ADDRWIDTH, 8, Sir address width
- DATAWIDTH, 32, Sir data width
- TOUTCYC, 16, maximum SirSel-high cycles without SirDack before a timeout (≥2)
- GAPCYC, 1, extra SirSel-low idle cycles after each transaction (≥1)
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- CmdValid  in  1  host command present
- CmdReady  out  1  block can accept a command this cycle
- CmdRead  in  1  1 = read, 0 = write
- CmdAddr  in  ADDRWIDTH  register address
- CmdWdat  in  DATAWIDTH  write data
- RspValid  out  1  one-cycle pulse, transaction finished
- RspRdat  out  DATAWIDTH  read data; 0 for writes and timeouts
- RspTimeout  out  1  valid with RspValid; 1 = no SirDack received
- SirSel  out  1  bus select
- SirRead  out  1  bus direction
- SirAddr  out  ADDRWIDTH  bus address
- SirWdat  out  DATAWIDTH  bus write data
- SirDack  in  1  OR of slave acknowledges
- SirRdat  in  DATAWIDTH  OR of slave read data

## Operation
- States:
  - IDLE: CmdReady=1.
  - SEL: SirSel=1.
  - RESP: SirSel=0, RspValid=1.
  - GAP: SirSel=0.
- IDLE→SEL on CmdValid&CmdReady.
  - On that edge, CmdRead, CmdAddr and CmdWdat are registered onto SirRead, SirAddr and SirWdat.
  - Sel count is set to 1.
- SEL:
  - SirAddr, SirWdat and SirRead stay constant throughout.
  - SirDack is ignored in the first SEL cycle, because it may be stale from the previous transaction.
  - From the 2nd SEL cycle on, SirDack=1 → RESP. RspRdat is loaded with SirRdat if the access is a read, else 0. RspTimeout is loaded with 0.
  - If the count reaches TOUTCYC without SirDack → RESP with RspTimeout=1 and RspRdat=0.
  - The count increments each SEL cycle and saturates. Its width is clog2(TOUTCYC+1).
  - The minimum SEL duration is 2 cycles. This is required because slaves commit a write on the cycle after detecting the rising edge of SirSel.
- RESP: single cycle. → GAP if GAPCYC>1, else IDLE.
- GAP: GAPCYC−1 cycles, then → IDLE.
  - SirSel is therefore low for at least GAPCYC+1 cycles between transactions.
  - This guarantees the slaves' SirSel edge detectors re-arm.
- CmdReady=0 in all states except IDLE. Commands are never dropped or queued.
- RspRdat and RspTimeout hold their values until the next RESP. RspValid has no backpressure.
- SirAddr, SirWdat and SirRead hold their last values outside SEL.
- SirDack and SirRdat are ignored outside SEL.

## Timing
- Reset values:
  - SirSel=0, SirRead=0, SirAddr=0, SirWdat=0.
  - CmdReady=0 while rst is high, and 1 in the first cycle after rst falls.
  - RspValid=0, RspRdat=0, RspTimeout=0.
  - State=IDLE, count=0.
- Nominal transaction with a single-cycle-registered slave (cycle 0 = command accept):
  - Cycles 1–2: SirSel=1.
  - Cycle 2: SirDack and SirRdat seen.
  - Cycle 3: RspValid; SirSel=0.
  - Cycle 4: IDLE, CmdReady=1.
  - Earliest next SirSel is cycle 5, when GAPCYC=1.
- A slave whose SirDack arrives in SEL cycle n (n≥2) gives RspValid n+1 cycles after accept.
- Timeout: SirSel is high for exactly TOUTCYC cycles. RspValid occurs at accept+TOUTCYC+1.
- If SirDack rises in the same cycle the count reaches TOUTCYC, it is an acknowledge, not a timeout.
- If rst is high at any edge, the block returns to reset values at that edge.
  - An in-flight transaction is abandoned with no RspValid.
  - SirSel drops at the next cycle.
- All outputs are registered. There is no combinational path from Cmd* or Sir* inputs to any output.

## Test plan
- Write 0x5A to 0x01 against a register-slave model initialised to 0:
  - SirSel is high in cycles 1–2.
  - The slave register reads 0x5A from cycle 3.
  - RspValid in cycle 3 with RspTimeout=0 and RspRdat=0.
- Read 0x01 after that write → RspValid in cycle 3 with RspRdat=0x5A and RspTimeout=0.
- Read unmapped 0x7F with TOUTCYC=16:
  - SirSel is high for exactly 16 cycles.
  - RspValid in cycle 17 with RspTimeout=1 and RspRdat=0.
- Back-to-back: CmdValid held high for writes 0x11→0x01 then 0x22→0x01, with GAPCYC=1:
  - SirSel is low in cycles 3–4; the second SirSel starts in cycle 5.
  - CmdReady=0 in cycles 1–3.
  - The slave ends holding 0x22.
  - Repeat with GAPCYC=3 and check SirSel is low for 4 cycles.
- Slow slave with SirDack delayed to the 5th SEL cycle, returning 0xDEADBEEF:
  - RspValid at accept+6 with RspRdat=0xDEADBEEF.
  - A stale SirDack held high in SEL cycle 1 is ignored.
- Assert rst in cycle 2 of a write:
  - SirSel=0 from cycle 3.
  - No RspValid is ever issued.
  - All outputs are at reset values.
  - CmdReady=1 the first cycle after rst falls, and a new write then completes normally.
